// File: rtl/ecc_pkg.sv
// ---------------------------------------------------------------------------
// ecc_pkg
//   Shared helpers for the SECDED check path.
//
//   ecc_hpos(i)        Hamming position of data bit i: the i-th integer >= 3
//                      that is not a power of two (3, 5, 6, 7, 9, 10, ...).
//   ecc_encode(d,w,p)  Check bits for a w-bit data word with p check bits.
//                      Data is passed zero-extended to ECC_MAX_DW and the
//                      result is returned in ECC_MAX_PW bits; callers narrow
//                      it with a size cast to their own parity width.
//   ECC_SYN_CLEAN      Syndrome value of an error-free word.
// ---------------------------------------------------------------------------
package ecc_pkg;

  localparam int ECC_SYN_CLEAN = 0;
  localparam int ECC_MAX_DW    = 128;
  localparam int ECC_MAX_PW    = 16;

  // Walks the positions upward, skipping powers of two (check-bit slots).
  function automatic int ecc_hpos(input int i);
    int pos;
    pos = 2;
    for (int j = 0; j <= i; j++) begin
      pos = pos + 1;
      if ((pos & (pos - 1)) == 0) pos = pos + 1;
    end
    return pos;
  endfunction

  function automatic logic [ECC_MAX_PW-1:0] ecc_encode(
    input logic [ECC_MAX_DW-1:0] data,
    input int                    dw,
    input int                    pw
  );
    logic [ECC_MAX_PW-1:0] p;
    int pos;
    p   = '0;
    pos = 2;
    for (int i = 0; i < dw; i++) begin
      pos = pos + 1;
      if ((pos & (pos - 1)) == 0) pos = pos + 1;
      for (int k = 0; k < pw - 1; k++) begin
        if (pos[k]) p[k] = p[k] ^ data[i];
      end
    end
    // Bits above pw-1 are still zero here, and data beyond dw is zero,
    // so a full-width reduction gives the overall parity bit.
    p[pw-1] = (^data) ^ (^p);
    return p;
  endfunction

endpackage

// File: rtl/ecc_secded_dec.sv
// ---------------------------------------------------------------------------
// ecc_secded_dec
//   Combinational syndrome decoder. Turns a syndrome into a data flip mask
//   and single/double error flags. Pure function of the syndrome so that a
//   write-side scrubber can reuse it unchanged.
//
//   Ports
//     syndrome   in   PARITY_WIDTH  stored check bits ^ recomputed check bits
//     flip_mask  out  DATA_WIDTH    one-hot bit to invert, or zero
//     sbit       out  1             correctable (data or check-bit) error
//     dbit       out  1             uncorrectable error
// ---------------------------------------------------------------------------
module ecc_secded_dec
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH   = 34,
  parameter int PARITY_WIDTH = 7
) (
  input  logic [PARITY_WIDTH-1:0] syndrome,
  output logic [DATA_WIDTH-1:0]   flip_mask,
  output logic                    sbit,
  output logic                    dbit
);

  localparam int LW = PARITY_WIDTH - 1;

  logic [LW-1:0]         lo;
  logic                  msb;
  logic [DATA_WIDTH-1:0] hit;
  logic                  lo_pow2_or_zero;

  assign lo  = syndrome[LW-1:0];
  assign msb = syndrome[LW];

  // Positions are elaboration constants; each data bit gets one comparator.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_hit
    localparam logic [LW-1:0] HP = LW'(ecc_hpos(gi));
    assign hit[gi] = (lo == HP);
  end

  // Zero or a single set bit: the error sits in a check bit.
  assign lo_pow2_or_zero = ((lo & (lo - LW'(1))) == '0);

  always_comb begin
    flip_mask = '0;
    sbit      = 1'b0;
    dbit      = 1'b0;
    if (msb) begin
      if (lo_pow2_or_zero) begin
        sbit = 1'b1;
      end else if (|hit) begin
        flip_mask = hit;
        sbit      = 1'b1;
      end else begin
        dbit = 1'b1;
      end
    end else if (lo != '0) begin
      dbit = 1'b1;
    end
  end

endmodule

// File: rtl/ecc_secded_pipe.sv
// ---------------------------------------------------------------------------
// ecc_secded_pipe
//   Two-stage SECDED check/correct stage for a FIFO read path, with a
//   valid/ready handshake, saturating error counters and a log of the first
//   uncorrectable syndrome since the last clear.
//
//   S1 registers data, syndrome and bypass; S2 registers corrected data and
//   flags. Both stages advance together whenever the output is empty or
//   being consumed, so in_ready is combinational from out_ready.
//
//   Ports
//     clk, rst_n            clock, synchronous active-low reset
//     in_valid/in_ready     input handshake
//     data_in, parity_in    RAM word and its stored check bits
//     bypass                pass the word raw: no correction, flags or counts
//     out_valid/out_ready   output handshake
//     data_out              corrected data
//     sbit_err, dbit_err    error flags, qualified by out_valid
//     syndrome              syndrome of the output word (zero when bypassed)
//     cnt_clr               clear counters and log
//     sbit_cnt, dbit_cnt    saturating counts of consumed error words
//     log_vld, log_syn      first double-error syndrome since clear
//
//   Build option ECC_ERR_INJECT_EN adds inj_mask/inj_en; when inj_en is set
//   the word is XORed with inj_mask before it is checked.
// ---------------------------------------------------------------------------
module ecc_secded_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH   = 34,
  parameter int PARITY_WIDTH = 7,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [PARITY_WIDTH-1:0] parity_in,
  input  logic                    bypass,
`ifdef ECC_ERR_INJECT_EN
  input  logic [DATA_WIDTH-1:0]   inj_mask,
  input  logic                    inj_en,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    sbit_err,
  output logic                    dbit_err,
  output logic [PARITY_WIDTH-1:0] syndrome,
  input  logic                    cnt_clr,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic                    log_vld,
  output logic [PARITY_WIDTH-1:0] log_syn
);

  if ((2 ** (PARITY_WIDTH - 1)) < (DATA_WIDTH + PARITY_WIDTH)) begin : g_bad_parity_width
    $error("ecc_secded_pipe: PARITY_WIDTH too small for DATA_WIDTH");
  end
  if (DATA_WIDTH > ECC_MAX_DW || PARITY_WIDTH > ECC_MAX_PW) begin : g_bad_max_width
    $error("ecc_secded_pipe: widths exceed ecc_pkg limits");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0]   data_eff;
  logic [PARITY_WIDTH-1:0] enc;
  logic                    adv;

  logic                    s1_valid;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic [PARITY_WIDTH-1:0] s1_syn;
  logic                    s1_bypass;

  logic [DATA_WIDTH-1:0]   dec_mask;
  logic                    dec_sbit;
  logic                    dec_dbit;

  logic                    out_hs;
  logic                    sbit_ev;
  logic                    dbit_ev;

`ifdef ECC_ERR_INJECT_EN
  assign data_eff = inj_en ? (data_in ^ inj_mask) : data_in;
`else
  assign data_eff = data_in;
`endif

  assign enc = PARITY_WIDTH'(ecc_encode(ECC_MAX_DW'(data_eff), DATA_WIDTH, PARITY_WIDTH));

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: capture word and its syndrome; a missing input becomes a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_syn    <= '0;
      s1_bypass <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data   <= data_eff;
        s1_syn    <= parity_in ^ enc;
        s1_bypass <= bypass;
      end
    end
  end

  ecc_secded_dec #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PARITY_WIDTH (PARITY_WIDTH)
  ) u_dec (
    .syndrome  (s1_syn),
    .flip_mask (dec_mask),
    .sbit      (dec_sbit),
    .dbit      (dec_dbit)
  );

  // Stage 2: corrected word and flags; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      sbit_err  <= 1'b0;
      dbit_err  <= 1'b0;
      syndrome  <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= s1_bypass ? s1_data : (s1_data ^ dec_mask);
        sbit_err <= !s1_bypass && dec_sbit;
        dbit_err <= !s1_bypass && dec_dbit;
        syndrome <= s1_bypass ? PARITY_WIDTH'(ECC_SYN_CLEAN) : s1_syn;
      end
    end
  end

  assign out_hs  = out_valid && out_ready;
  assign sbit_ev = out_hs && sbit_err;
  assign dbit_ev = out_hs && dbit_err;

  // A clear coinciding with an event behaves as clear-then-count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
      log_vld  <= 1'b0;
      log_syn  <= '0;
    end else begin
      if (cnt_clr) begin
        sbit_cnt <= sbit_ev ? CNT_ONE : '0;
      end else if (sbit_ev && (sbit_cnt != '1)) begin
        sbit_cnt <= sbit_cnt + CNT_ONE;
      end

      if (cnt_clr) begin
        dbit_cnt <= dbit_ev ? CNT_ONE : '0;
      end else if (dbit_ev && (dbit_cnt != '1)) begin
        dbit_cnt <= dbit_cnt + CNT_ONE;
      end

      if (cnt_clr) begin
        log_vld <= dbit_ev;
        log_syn <= dbit_ev ? syndrome : '0;
      end else if (dbit_ev && !log_vld) begin
        log_vld <= 1'b1;
        log_syn <= syndrome;
      end
    end
  end

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// ---------------------------------------------------------------------------
// tb_ecc_secded_pipe
//   Self-checking bench for ecc_secded_pipe (default build, DW=34, P=7).
//   A queue-based reference model derives every expected output from the
//   code construction and decode rules; a vector table adds constant
//   expectations for hand-built error words.
// ---------------------------------------------------------------------------
module tb_ecc_secded_pipe;

  localparam int DW = 34;
  localparam int PW = 7;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic [PW-1:0] parity_in;
  logic          bypass;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic          sbit_err;
  logic          dbit_err;
  logic [PW-1:0] syndrome;
  logic          cnt_clr;
  logic [CW-1:0] sbit_cnt;
  logic [CW-1:0] dbit_cnt;
  logic          log_vld;
  logic [PW-1:0] log_syn;

  always #5 clk = ~clk;

  ecc_secded_pipe #(
    .DATA_WIDTH   (DW),
    .PARITY_WIDTH (PW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .parity_in (parity_in),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .sbit_err  (sbit_err),
    .dbit_err  (dbit_err),
    .syndrome  (syndrome),
    .cnt_clr   (cnt_clr),
    .sbit_cnt  (sbit_cnt),
    .dbit_cnt  (dbit_cnt),
    .log_vld   (log_vld),
    .log_syn   (log_syn)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          sb;
    logic          db;
    logic [PW-1:0] syn;
    logic          byp;
  } exp_t;

  typedef struct {
    string         name;
    logic [DW-1:0] data;
    logic [PW-1:0] par;
    logic          byp;
    logic [DW-1:0] exp_data;
    logic          exp_sb;
    logic          exp_db;
    logic [PW-1:0] exp_syn;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   hp[DW];
  exp_t sb_q[$];
  int   m_scnt = 0;
  int   m_dcnt = 0;
  logic m_lvld = 1'b0;
  logic [PW-1:0] m_lsyn = '0;
  logic last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Check bits from the positional definition.
  function automatic logic [PW-1:0] m_enc(input logic [DW-1:0] d);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < PW - 1; k++)
      for (int i = 0; i < DW; i++)
        if (((hp[i] >> k) & 1) == 1) p[k] = p[k] ^ d[i];
    p[PW-1] = (^d) ^ (^p[PW-2:0]);
    return p;
  endfunction

  function automatic exp_t m_dec(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic byp);
    exp_t e;
    logic [PW-1:0] s;
    int lo;
    e.data = d; e.sb = 1'b0; e.db = 1'b0; e.syn = '0; e.byp = byp;
    if (byp) return e;
    s     = p ^ m_enc(d);
    e.syn = s;
    lo    = int'(s[PW-2:0]);
    if (s == '0) begin
    end else if (!s[PW-1]) begin
      e.db = 1'b1;
    end else if ($countones(lo) <= 1) begin
      e.sb = 1'b1;
    end else begin
      e.db = 1'b1;
      for (int i = 0; i < DW; i++)
        if (hp[i] == lo) begin
          e.db = 1'b0; e.sb = 1'b1; e.data[i] = ~d[i];
        end
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // kind: 0 clean, 1 one data bit, 2 two data bits, 3 check-bit corruption
  task automatic drive_word(input int kind);
    logic [DW-1:0] d;
    int b1, b2;
    d = rnd_data();
    parity_in = m_enc(d);
    b1 = int'($urandom_range(DW - 1));
    b2 = (b1 + 1 + int'($urandom_range(DW - 2))) % DW;
    case (kind)
      1: d = d ^ (DW'(1) << b1);
      2: d = d ^ (DW'(1) << b1) ^ (DW'(1) << b2);
      3: parity_in = parity_in ^ PW'($urandom_range(1, 127));
      default: ;
    endcase
    data_in = d;
  endtask

  // One clock: score an output handshake, record an input handshake.
  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic tick();
    exp_t e;
    logic hs, hsb, hdb;
    logic [PW-1:0] hsyn;
    hs = 1'b0; hsb = 1'b0; hdb = 1'b0; hsyn = '0;
    #1;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out", 64'(out_valid), 64'(0));
      end else begin
        e = sb_q.pop_front();
        chk("sb_data", 64'(data_out), 64'(e.data));
        chk("sb_sbit", 64'(sbit_err), 64'(e.sb));
        chk("sb_dbit", 64'(dbit_err), 64'(e.db));
        if (!e.byp) chk("sb_syn", 64'(syndrome), 64'(e.syn));
        hs = 1'b1; hsb = e.sb; hdb = e.db; hsyn = e.syn;
      end
    end
    if (cnt_clr) begin
      m_scnt = (hs && hsb) ? 1 : 0;
      m_dcnt = (hs && hdb) ? 1 : 0;
      m_lvld = hs && hdb;
      m_lsyn = (hs && hdb) ? hsyn : '0;
    end else begin
      if (hs && hsb && m_scnt < 65535) m_scnt++;
      if (hs && hdb && m_dcnt < 65535) m_dcnt++;
      if (hs && hdb && !m_lvld) begin m_lvld = 1'b1; m_lsyn = hsyn; end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) sb_q.push_back(m_dec(data_in, parity_in, bypass));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_sbit_cnt"}, 64'(sbit_cnt), 64'(m_scnt));
    chk({tag, "_dbit_cnt"}, 64'(dbit_cnt), 64'(m_dcnt));
    chk({tag, "_log_vld"},  64'(log_vld),  64'(m_lvld));
    chk({tag, "_log_syn"},  64'(log_syn),  64'(m_lsyn));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drain_queue_empty", 64'(sb_q.size()), 64'(0));
  endtask

  vec_t tbl[8];

  initial begin
    logic [DW-1:0] base;
    logic [PW-1:0] bp;
    logic [DW-1:0] hold_d;
    logic [CW-1:0] hold_c;
    int w;

    begin
      int n, c;
      n = 3; c = 0;
      while (c < DW) begin
        if ($countones(n) != 1) begin hp[c] = n; c++; end
        n++;
      end
    end

    base = 34'h2DEADBEEF;
    bp   = m_enc(base);
    tbl[0] = '{"clean",       base,              bp,           1'b0, base,              1'b0, 1'b0, 7'h00};
    tbl[1] = '{"flip_d0",     base ^ 34'h1,      bp,           1'b0, base,              1'b1, 1'b0, 7'h43};
    tbl[2] = '{"flip_d1",     base ^ 34'h2,      bp,           1'b0, base,              1'b1, 1'b0, 7'h45};
    tbl[3] = '{"flip_d33",    base ^ (34'h1 << 33), bp,        1'b0, base,              1'b1, 1'b0, 7'h68};
    tbl[4] = '{"flip_p6",     base,              bp ^ 7'h40,   1'b0, base,              1'b1, 1'b0, 7'h40};
    tbl[5] = '{"flip_d0_d5",  base ^ 34'h21,     bp,           1'b0, base ^ 34'h21,     1'b0, 1'b1, 7'h09};
    tbl[6] = '{"bypass_dbl",  base ^ 34'h21,     bp,           1'b1, base ^ 34'h21,     1'b0, 1'b0, 7'h00};
    tbl[7] = '{"second_dbl",  base ^ 34'h3,      bp,           1'b0, base ^ 34'h3,      1'b0, 1'b1, 7'h06};

    rst_n = 1'b0; in_valid = 1'b0; data_in = '0; parity_in = '0; bypass = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_data_out",  64'(data_out),  64'(0));
    chk("rst_syndrome",  64'(syndrome),  64'(0));
    chk("rst_sbit_cnt",  64'(sbit_cnt),  64'(0));
    chk("rst_log_vld",   64'(log_vld),   64'(0));

    // 100 clean words at full throughput.
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_word(0);
      tick();
    end
    drain();
    chk("clean_sbit_cnt", 64'(sbit_cnt), 64'(0));
    chk("clean_dbit_cnt", 64'(dbit_cnt), 64'(0));
    chk("clean_log_vld",  64'(log_vld),  64'(0));

    // Vector table, one word at a time, counters freshly cleared.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    for (int v = 0; v < 8; v++) begin
      data_in = tbl[v].data; parity_in = tbl[v].par; bypass = tbl[v].byp;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0; bypass = 1'b0;
      w = 1;
      while (!out_valid && w < 8) begin tick(); w++; end
      chk({tbl[v].name, "_latency"}, 64'(w), 64'(2));
      chk({tbl[v].name, "_data"}, 64'(data_out), 64'(tbl[v].exp_data));
      chk({tbl[v].name, "_sbit"}, 64'(sbit_err), 64'(tbl[v].exp_sb));
      chk({tbl[v].name, "_dbit"}, 64'(dbit_err), 64'(tbl[v].exp_db));
      if (!tbl[v].byp) chk({tbl[v].name, "_syn"}, 64'(syndrome), 64'(tbl[v].exp_syn));
      tick();
      if (v == 6) begin
        chk("after_bypass_dbit_cnt", 64'(dbit_cnt), 64'(1));
        chk("after_bypass_log_syn",  64'(log_syn),  64'(7'h09));
      end
    end
    chk("tbl_sbit_cnt", 64'(sbit_cnt), 64'(4));
    chk("tbl_dbit_cnt", 64'(dbit_cnt), 64'(2));
    chk("tbl_log_vld",  64'(log_vld),  64'(1));
    chk("tbl_log_syn",  64'(log_syn),  64'(7'h09));
    chk_model("tbl");

    // Random traffic with random errors and random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      drive_word(int'($urandom_range(3)));
      tick();
    end
    drain();
    chk_model("rand");

    // Stall with the pipe full: outputs frozen, nothing counted or lost.
    out_ready = 1'b0; in_valid = 1'b1;
    drive_word(1);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (last_acc) drive_word(1);
    end
    hold_d = data_out;
    hold_c = sbit_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready",  64'(in_ready),  64'(0));
      chk("stall_out_valid", 64'(out_valid), 64'(1));
      chk("stall_data_out",  64'(data_out),  64'(hold_d));
      chk("stall_sbit_cnt",  64'(sbit_cnt),  64'(hold_c));
      tick();
      if (last_acc) drive_word(1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (last_acc) drive_word(1);
    end
    drain();
    chk_model("stall");

    // Saturation of sbit_cnt, then clear coinciding with an sbit handshake.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      drive_word(0);
      data_in[0] = ~data_in[0];
      tick();
    end
    chk("sat_reach_ffff", 64'(sbit_cnt), 64'(16'hFFFF));
    drive_word(0); data_in[0] = ~data_in[0];
    tick();
    chk("sat_hold_ffff", 64'(sbit_cnt), 64'(16'hFFFF));
    cnt_clr = 1'b1;
    drive_word(0); data_in[0] = ~data_in[0];
    tick();
    cnt_clr = 1'b0;
    chk("clr_with_event", 64'(sbit_cnt), 64'(1));
    chk_model("sat");

    // Reset in the middle of a stream.
    for (int i = 0; i < 3; i++) begin
      drive_word(2);
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_dbit_cnt",  64'(dbit_cnt),  64'(0));
    chk("midrst_log_vld",   64'(log_vld),   64'(0));
    sb_q.delete();
    m_scnt = 0; m_dcnt = 0; m_lvld = 1'b0; m_lsyn = '0;
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("postrst_out_valid", 64'(out_valid), 64'(0));
    chk("postrst_in_ready",  64'(in_ready),  64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
